branch_cmp_unit: RTL and testbench

Parametrised successor to the D-stage branch comparator. It evaluates all MIPS branch conditions (beq/bne/blez/bgtz/bltz/bgez plus slt/sltu-style compares) on WIDTH-bit operands. The result is held in a one-entry output register behind a valid/ready handshake, so a stalled pipeline keeps the resolved condition. It also keeps saturating taken/total counters for performance analysis. It sits between the D-stage forwarding muxes and the NPC/flush logic.

---
 rtl/branch_cmp_unit_pkg.sv | 17 +
 rtl/branch_cmp_unit_cmp_core.sv | 44 ++++
 rtl/branch_cmp_unit.sv | 98 +++++++++
 tb/tb_branch_cmp_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_cmp_unit_pkg.sv
// Shared op encodings and counter helper for the branch compare unit.
package branch_cmp_unit_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LEZ = 3'd2,
    CMP_GTZ = 3'd3,
    CMP_LTZ = 3'd4,
    CMP_GEZ = 3'd5,
    CMP_LT  = 3'd6,
    CMP_LTU = 3'd7
  } cmp_op_e;

  localparam int OP_W = 3;

endpackage

// File: rtl/branch_cmp_unit_cmp_core.sv
// Combinational evaluation of all MIPS branch/compare conditions on WIDTH-bit operands.
// Zero latency; no handshake of its own.
module cmp_core
  import branch_cmp_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cond,
  output logic             err
);

  logic a_neg;
  logic a_zero;
  logic eq;
  logic lt_s;
  logic lt_u;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);
  assign eq     = (a == b);
  assign lt_s   = ($signed(a) < $signed(b));
  assign lt_u   = (a < b);

  always_comb begin
    cond = 1'b0;
    // Every 3-bit encoding is defined; err is reserved for a wider op field.
    err  = 1'b0;
    case (cmp_op_e'(op))
      CMP_EQ:  cond = eq;
      CMP_NE:  cond = !eq;
      CMP_LEZ: cond = a_neg || a_zero;
      CMP_GTZ: cond = !a_neg && !a_zero;
      CMP_LTZ: cond = a_neg;
      CMP_GEZ: cond = !a_neg;
      CMP_LT:  cond = lt_s;
      CMP_LTU: cond = lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_unit.sv
// Branch condition register behind valid/ready, plus saturating taken/total counters.
// One-cycle latency; result held while out_ready=0, in_ready = !out_valid || out_ready.
module branch_cmp_unit
  import branch_cmp_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cond,
  output logic             err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             core_cond;
  logic             core_err;
  logic             accept;
  logic             out_valid_q, out_valid_d;
  logic             cond_q, cond_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] total_q, total_d;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .op   (op),
    .a    (a),
    .b    (b),
    .cond (core_cond),
    .err  (core_err)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    cond_d      = cond_q;
    err_d       = err_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      cond_d      = core_cond;
      err_d       = core_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Counters ignore flush; clear wins over a same-cycle increment.
  always_comb begin
    taken_d = taken_q;
    total_d = total_q;
    if (cnt_clr) begin
      taken_d = '0;
      total_d = '0;
    end else if (accept) begin
      if (total_q != CNT_MAX) total_d = total_q + 1'b1;
      if (core_cond && (taken_q != CNT_MAX)) taken_d = taken_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      cond_q      <= 1'b0;
      err_q       <= 1'b0;
      taken_q     <= '0;
      total_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cond_q      <= cond_d;
      err_q       <= err_d;
      taken_q     <= taken_d;
      total_q     <= total_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cond      = cond_q;
  assign err       = err_q;
  assign taken_cnt = taken_q;
  assign total_cnt = total_q;

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed bench: a 16-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_branch_cmp_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, cond, err;
  logic [15:0] taken_cnt, total_cnt;
  logic        s_in_ready, s_out_valid, s_cond, s_err;
  logic [1:0]  s_taken_cnt, s_total_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_cmp_unit #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .cond(cond), .err(err), .cnt_clr(cnt_clr),
    .taken_cnt(taken_cnt), .total_cnt(total_cnt)
  );

  branch_cmp_unit #(.WIDTH(32), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .cond(s_cond), .err(s_err), .cnt_clr(cnt_clr),
    .taken_cnt(s_taken_cnt), .total_cnt(s_total_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
  endtask

  // Directed mode vectors: op, a, b, expected cond
  logic [2:0]  m_op  [11];
  logic [31:0] m_a   [11];
  logic [31:0] m_b   [11];
  logic        m_exp [11];

  logic [2:0]  bb_op  [4];
  logic [31:0] bb_a   [4];
  logic [31:0] bb_b   [4];
  logic        bb_exp [4];

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_op[i] = 3'(i);
      m_a[i]  = 32'h8000_0000;
      m_b[i]  = 32'h0000_0001;
    end
    m_exp[0] = 1'b0; m_exp[1] = 1'b1; m_exp[2] = 1'b1; m_exp[3] = 1'b0;
    m_exp[4] = 1'b1; m_exp[5] = 1'b0; m_exp[6] = 1'b1; m_exp[7] = 1'b0;
    m_op[8]  = 3'd0; m_a[8]  = 32'd0; m_b[8]  = 32'd0; m_exp[8]  = 1'b1;
    m_op[9]  = 3'd2; m_a[9]  = 32'd0; m_b[9]  = 32'd0; m_exp[9]  = 1'b1;
    m_op[10] = 3'd3; m_a[10] = 32'd0; m_b[10] = 32'd0; m_exp[10] = 1'b0;

    bb_op[0] = 3'd0; bb_a[0] = 32'd1;         bb_b[0] = 32'd1; bb_exp[0] = 1'b1;
    bb_op[1] = 3'd1; bb_a[1] = 32'd1;         bb_b[1] = 32'd1; bb_exp[1] = 1'b0;
    bb_op[2] = 3'd7; bb_a[2] = 32'd2;         bb_b[2] = 32'd3; bb_exp[2] = 1'b1;
    bb_op[3] = 3'd5; bb_a[3] = 32'hFFFF_FFFF; bb_b[3] = 32'd0; bb_exp[3] = 1'b0;

    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cond", {31'd0, cond}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_taken", {16'd0, taken_cnt}, 32'd0);
    chk("rst_total", {16'd0, total_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while holding a result
    reset = 1'b1;
    drive(1'b1, 3'd0, 32'd0, 32'd0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("hold_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_pre_total", {16'd0, total_cnt}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_taken", {16'd0, taken_cnt}, 32'd0);
    chk("midrst_total", {16'd0, total_cnt}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    // All modes, streamed back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, m_op[i], m_a[i], m_b[i]);
      tick();
      chk($sformatf("mode%0d_cond", i), {31'd0, cond}, {31'd0, m_exp[i]});
      chk($sformatf("mode%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("mode%0d_err", i), {31'd0, err}, 32'd0);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("modes_total", {16'd0, total_cnt}, 32'd11);
    chk("modes_taken", {16'd0, taken_cnt}, 32'd6);
    chk("modes_sat_total", {30'd0, s_total_cnt}, 32'd3);
    chk("modes_sat_taken", {30'd0, s_taken_cnt}, 32'd3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_total", {16'd0, total_cnt}, 32'd0);
    chk("clr_taken", {16'd0, taken_cnt}, 32'd0);

    // Stall hold: operands change underneath a held result
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'd5, 32'd5);
    tick();
    chk("stall_first_cond", {31'd0, cond}, 32'd1);
    a = 32'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_cond", i), {31'd0, cond}, 32'd1);
      chk($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("stall%0d_total", i), {16'd0, total_cnt}, 32'd1);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("stall_drain_valid", {31'd0, out_valid}, 32'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bb_op[i], bb_a[i], bb_b[i]);
      tick();
      chk($sformatf("b2b%0d_cond", i), {31'd0, cond}, {31'd0, bb_exp[i]});
      chk($sformatf("b2b%0d_valid", i), {31'd0, out_valid}, 32'd1);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    chk("b2b_taken", {16'd0, taken_cnt}, 32'd2);
    chk("b2b_total", {16'd0, total_cnt}, 32'd4);
    chk("b2b_sat_total", {30'd0, s_total_cnt}, 32'd3);
    chk("b2b_sat_taken", {30'd0, s_taken_cnt}, 32'd2);

    // Flush beats a same-cycle accept
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'd1, 32'd1);
    tick();
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_pre_total", {16'd0, total_cnt}, 32'd5);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_total", {16'd0, total_cnt}, 32'd5);
    chk("flush_taken", {16'd0, taken_cnt}, 32'd3);

    // Saturation on the 2-bit counters, then clear beating an accept
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd0, 32'd7, 32'd7);
      tick();
    end
    chk("sat_taken", {30'd0, s_taken_cnt}, 32'd3);
    chk("sat_total", {30'd0, s_total_cnt}, 32'd3);
    chk("nosat_total", {16'd0, total_cnt}, 32'd5);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("clr_acc_sat_taken", {30'd0, s_taken_cnt}, 32'd0);
    chk("clr_acc_sat_total", {30'd0, s_total_cnt}, 32'd0);
    chk("clr_acc_total", {16'd0, total_cnt}, 32'd0);
    chk("clr_acc_valid", {31'd0, out_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
